// File: rtl/striping_defs.sv
// striping_defs: shared definitions for the two-lane striping scheduler.
//   - FSM state encodings (state_t)
//   - default idle / training fill words
//   - lane configuration encodings
package striping_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_TRAIN  = 2'b01,
    ST_ACTIVE = 2'b10
  } state_t;

  localparam logic [31:0] DEF_IDLE_WORD  = 32'hBCBCBCBC;
  localparam logic [31:0] DEF_TRAIN_WORD = 32'h4A4A4A4A;

  localparam logic CFG_SINGLE = 1'b0;
  localparam logic CFG_DUAL   = 1'b1;

endpackage

// File: rtl/striping_scheduler_train_counter.sv
// train_counter: saturating cycle counter for the training burst.
// Ports:
//   clk_2f  in  clock
//   reset   in  asynchronous active-high reset
//   clear   in  restart the count at zero
//   inc     in  advance the count (holds once the last cycle is reached)
//   done    out count has reached TRAIN_LEN-1 (last training cycle)
module train_counter #(
  parameter int TRAIN_LEN = 4
) (
  input  logic clk_2f,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic done
);

  localparam int CW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(TRAIN_LEN - 1);

  logic [CW-1:0] count;

  // Training cycle count, saturating at the last training cycle
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      count <= {CW{1'b0}};
    end else if (clear) begin
      count <= {CW{1'b0}};
    end else if (inc && (count != LAST)) begin
      count <= count + CW'(1'b1);
    end else begin
      count <= count;
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/striping_scheduler.sv
// striping_scheduler: bring-up FSM and lane mux for a two-lane byte-striping
// datapath. IDLE -> TRAIN (TRAIN_LEN cycles of TRAIN_WORD) -> ACTIVE, where
// accepted words are distributed round-robin over the enabled lanes.
// Ports:
//   clk_2f, reset          clock, asynchronous active-high reset
//   enable                 link enable (low returns the link to IDLE)
//   lane_cfg               0 single lane, 1 dual lane; latched entering TRAIN
//   valid_in, data_in      upstream word; ready_out accepts it (combinational)
//   valid_0/lane_0,
//   valid_1/lane_1         registered lane outputs, IDLE_WORD when empty
//   training               lanes carry TRAIN_WORD
//   state_out              00 IDLE, 01 TRAIN, 10 ACTIVE
//   word_count             accepted words, wraps at 2^CNT_W
module striping_scheduler
  import striping_defs::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] IDLE_WORD  = DATA_W'(DEF_IDLE_WORD),
  parameter logic [DATA_W-1:0] TRAIN_WORD = DATA_W'(DEF_TRAIN_WORD),
  parameter int                TRAIN_LEN  = 4,
  parameter int                CNT_W      = 16
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              enable,
  input  logic              lane_cfg,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  output logic              valid_0,
  output logic [DATA_W-1:0] lane_0,
  output logic              valid_1,
  output logic [DATA_W-1:0] lane_1,
  output logic              training,
  output logic [1:0]        state_out,
  output logic [CNT_W-1:0]  word_count
);

  state_t            state, state_nxt;
  logic              ptr, ptr_nxt;
  logic              cfg_q, cfg_nxt;
  logic              accept;
  logic              cnt_clear, cnt_inc, cnt_done;
  logic [DATA_W-1:0] lane_0_nxt, lane_1_nxt;
  logic              valid_0_nxt, valid_1_nxt, training_nxt;

  assign ready_out = (state == ST_ACTIVE) && enable;
  assign accept    = valid_in && ready_out;
  assign state_out = state;

  train_counter #(.TRAIN_LEN(TRAIN_LEN)) u_train_counter (
    .clk_2f (clk_2f),
    .reset  (reset),
    .clear  (cnt_clear),
    .inc    (cnt_inc),
    .done   (cnt_done)
  );

  // FSM state register
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the lane values to register at the coming edge.
  // Outputs are decoded from the transition so they line up with state_out.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    cfg_nxt      = cfg_q;
    cnt_clear    = 1'b0;
    cnt_inc      = 1'b0;
    lane_0_nxt   = IDLE_WORD;
    lane_1_nxt   = IDLE_WORD;
    valid_0_nxt  = 1'b0;
    valid_1_nxt  = 1'b0;
    training_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt    = ST_TRAIN;
          cfg_nxt      = lane_cfg;
          cnt_clear    = 1'b1;
          training_nxt = 1'b1;
          lane_0_nxt   = TRAIN_WORD;
          // Lane 1 trains only when the configuration being latched is dual
          if (lane_cfg == CFG_DUAL) begin
            lane_1_nxt = TRAIN_WORD;
          end else begin
            lane_1_nxt = IDLE_WORD;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_TRAIN: begin
        cnt_inc = 1'b1;
        if (!enable) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = 1'b0;
        end else if (cnt_done) begin
          state_nxt = ST_ACTIVE;
        end else begin
          training_nxt = 1'b1;
          lane_0_nxt   = TRAIN_WORD;
          if (cfg_q == CFG_DUAL) begin
            lane_1_nxt = TRAIN_WORD;
          end else begin
            lane_1_nxt = IDLE_WORD;
          end
        end
      end
      ST_ACTIVE: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = 1'b0;
        end else if (accept) begin
          if (ptr == 1'b0) begin
            lane_0_nxt  = data_in;
            valid_0_nxt = 1'b1;
          end else begin
            lane_1_nxt  = data_in;
            valid_1_nxt = 1'b1;
          end
          // Single lane pins the pointer at lane 0
          if (cfg_q == CFG_DUAL) begin
            ptr_nxt = ~ptr;
          end else begin
            ptr_nxt = 1'b0;
          end
        end else begin
          ptr_nxt = ptr;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        ptr_nxt   = 1'b0;
      end
    endcase
  end

  // Lane outputs, lane pointer, latched configuration and word counter
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      ptr        <= 1'b0;
      cfg_q      <= CFG_SINGLE;
      lane_0     <= IDLE_WORD;
      lane_1     <= IDLE_WORD;
      valid_0    <= 1'b0;
      valid_1    <= 1'b0;
      training   <= 1'b0;
      word_count <= {CNT_W{1'b0}};
    end else begin
      ptr      <= ptr_nxt;
      cfg_q    <= cfg_nxt;
      lane_0   <= lane_0_nxt;
      lane_1   <= lane_1_nxt;
      valid_0  <= valid_0_nxt;
      valid_1  <= valid_1_nxt;
      training <= training_nxt;
      if (accept) begin
        word_count <= word_count + CNT_W'(1'b1);
      end else begin
        word_count <= word_count;
      end
    end
  end

endmodule

// File: tb/tb_striping_scheduler.sv
// tb_striping_scheduler: directed self-checking bench for striping_scheduler.
// A second instance with CNT_W = 4 shares all inputs to observe counter wrap.
module tb_striping_scheduler;

  localparam logic [31:0] IW = 32'hBCBCBCBC;
  localparam logic [31:0] TW = 32'h4A4A4A4A;

  logic        clk_2f = 1'b0;
  logic        reset, enable, lane_cfg, valid_in;
  logic [31:0] data_in;
  logic        ready_out, valid_0, valid_1, training;
  logic [31:0] lane_0, lane_1;
  logic [1:0]  state_out;
  logic [15:0] word_count;

  logic        s_ready, s_v0, s_v1, s_trn;
  logic [31:0] s_l0, s_l1;
  logic [1:0]  s_st;
  logic [3:0]  s_wc;

  int checks = 0;
  int errors = 0;

  always #5 clk_2f = ~clk_2f;

  striping_scheduler dut (
    .clk_2f(clk_2f), .reset(reset), .enable(enable), .lane_cfg(lane_cfg),
    .valid_in(valid_in), .data_in(data_in), .ready_out(ready_out),
    .valid_0(valid_0), .lane_0(lane_0), .valid_1(valid_1), .lane_1(lane_1),
    .training(training), .state_out(state_out), .word_count(word_count)
  );

  striping_scheduler #(.CNT_W(4)) dut4 (
    .clk_2f(clk_2f), .reset(reset), .enable(enable), .lane_cfg(lane_cfg),
    .valid_in(valid_in), .data_in(data_in), .ready_out(s_ready),
    .valid_0(s_v0), .lane_0(s_l0), .valid_1(s_v1), .lane_1(s_l1),
    .training(s_trn), .state_out(s_st), .word_count(s_wc)
  );

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  // Bring-up from IDLE: 4 training cycles, then ACTIVE with ready high.
  // lane_cfg is flipped after the first edge to show it is not re-sampled.
  task automatic train_and_check(input logic cfg);
    logic [31:0] exp1;
    exp1 = cfg ? TW : IW;
    enable = 1'b1;
    lane_cfg = cfg;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) lane_cfg = ~cfg;
      checks++;
      if (training !== 1'b1 || state_out !== 2'b01 || lane_0 !== TW || lane_1 !== exp1 ||
          valid_0 !== 1'b0 || valid_1 !== 1'b0) begin
        errors++;
        $display("FAIL train_cycle%0d cfg=%b: got trn=%b st=%b l0=%h l1=%h v=%b%b, want trn=1 st=01 l0=%h l1=%h v=00",
                 i, cfg, training, state_out, lane_0, lane_1, valid_1, valid_0, TW, exp1);
      end
    end
    tick();
    lane_cfg = cfg;
    checks++;
    if (state_out !== 2'b10 || training !== 1'b0 || ready_out !== 1'b1 || lane_0 !== IW ||
        lane_1 !== IW || valid_0 !== 1'b0 || valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL train_to_active: got st=%b trn=%b rdy=%b l0=%h l1=%h v=%b%b, want st=10 trn=0 rdy=1 idle lanes",
               state_out, training, ready_out, lane_0, lane_1, valid_1, valid_0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; lane_cfg = 1'b1; valid_in = 1'b0; data_in = 32'h0;
    tick();
    tick();
    checks++;
    if (state_out !== 2'b00 || lane_0 !== IW || lane_1 !== IW || valid_0 !== 1'b0 || valid_1 !== 1'b0 ||
        training !== 1'b0 || word_count !== 16'd0 || ready_out !== 1'b0 || s_wc !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: got st=%b l0=%h l1=%h v=%b%b trn=%b wc=%0d rdy=%b wc4=%0d",
               state_out, lane_0, lane_1, valid_1, valid_0, training, word_count, ready_out, s_wc);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (state_out !== 2'b00 || lane_0 !== IW || lane_1 !== IW || valid_0 !== 1'b0 || valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got st=%b l0=%h l1=%h v=%b%b, want 00 idle lanes",
               state_out, lane_0, lane_1, valid_1, valid_0);
    end
  endtask

  task automatic test_dual_striping();
    logic [31:0] w [4];
    w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    train_and_check(1'b1);
    for (int i = 0; i < 4; i++) begin
      valid_in = 1'b1;
      data_in = w[i];
      tick();
      checks++;
      if ((i % 2) == 0) begin
        if (valid_0 !== 1'b1 || valid_1 !== 1'b0 || lane_0 !== w[i] || lane_1 !== IW) begin
          errors++;
          $display("FAIL dual_word%0d: got l0=%h l1=%h v=%b%b, want l0=%h on lane 0 only",
                   i, lane_0, lane_1, valid_1, valid_0, w[i]);
        end
      end else begin
        if (valid_0 !== 1'b0 || valid_1 !== 1'b1 || lane_1 !== w[i] || lane_0 !== IW) begin
          errors++;
          $display("FAIL dual_word%0d: got l0=%h l1=%h v=%b%b, want l1=%h on lane 1 only",
                   i, lane_0, lane_1, valid_1, valid_0, w[i]);
        end
      end
    end
    valid_in = 1'b0;
    tick();
    checks++;
    if (valid_0 !== 1'b0 || valid_1 !== 1'b0 || lane_0 !== IW || lane_1 !== IW || word_count !== 16'd4) begin
      errors++;
      $display("FAIL dual_after: got l0=%h l1=%h v=%b%b wc=%0d, want idle lanes wc=4",
               lane_0, lane_1, valid_1, valid_0, word_count);
    end
  endtask

  task automatic test_gap();
    valid_in = 1'b1; data_in = 32'hAAAA0001;
    tick();
    checks++;
    if (valid_0 !== 1'b1 || valid_1 !== 1'b0 || lane_0 !== 32'hAAAA0001 || lane_1 !== IW) begin
      errors++;
      $display("FAIL gap_word_a: got l0=%h l1=%h v=%b%b, want l0=aaaa0001 v=01", lane_0, lane_1, valid_1, valid_0);
    end
    valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (valid_0 !== 1'b0 || valid_1 !== 1'b0 || lane_0 !== IW || lane_1 !== IW) begin
        errors++;
        $display("FAIL gap_idle%0d: got l0=%h l1=%h v=%b%b, want idle lanes", i, lane_0, lane_1, valid_1, valid_0);
      end
    end
    valid_in = 1'b1; data_in = 32'hBBBB0002;
    tick();
    valid_in = 1'b0;
    checks++;
    if (valid_0 !== 1'b0 || valid_1 !== 1'b1 || lane_1 !== 32'hBBBB0002 || lane_0 !== IW || word_count !== 16'd6) begin
      errors++;
      $display("FAIL gap_word_b: got l0=%h l1=%h v=%b%b wc=%0d, want l1=bbbb0002 v=10 wc=6",
               lane_0, lane_1, valid_1, valid_0, word_count);
    end
  endtask

  task automatic test_single_lane();
    logic [31:0] w [3];
    w = '{32'hC0000001, 32'hC0000002, 32'hC0000003};
    enable = 1'b0;
    tick();
    checks++;
    if (state_out !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got st=%b, want 00", state_out);
    end
    train_and_check(1'b0);
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in = w[i];
      tick();
      if (i == 0) lane_cfg = 1'b1;
      checks++;
      if (valid_0 !== 1'b1 || valid_1 !== 1'b0 || lane_0 !== w[i] || lane_1 !== IW) begin
        errors++;
        $display("FAIL single_word%0d: got l0=%h l1=%h v=%b%b, want l0=%h v=01",
                 i, lane_0, lane_1, valid_1, valid_0, w[i]);
      end
    end
    valid_in = 1'b0;
    tick();
    checks++;
    if (word_count !== 16'd9 || valid_1 !== 1'b0) begin
      errors++;
      $display("FAIL single_count: got wc=%0d v1=%b, want wc=9 v1=0", word_count, valid_1);
    end
  endtask

  task automatic test_disable_reenable();
    enable = 1'b0;
    tick();
    train_and_check(1'b1);
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1;
      data_in = 32'hD0000000 + i;
      tick();
      checks++;
      if ((i % 2) == 0 ? (valid_0 !== 1'b1 || lane_0 !== 32'hD0000000 + i || valid_1 !== 1'b0)
                       : (valid_1 !== 1'b1 || lane_1 !== 32'hD0000000 + i || valid_0 !== 1'b0)) begin
        errors++;
        $display("FAIL dis_word%0d: got l0=%h l1=%h v=%b%b", i, lane_0, lane_1, valid_1, valid_0);
      end
    end
    // Drop enable with a word still offered: it must not be taken
    enable = 1'b0;
    valid_in = 1'b1;
    data_in = 32'hDEAD0000;
    #1;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL dis_ready: got rdy=%b, want 0", ready_out);
    end
    tick();
    checks++;
    if (state_out !== 2'b00 || valid_0 !== 1'b0 || valid_1 !== 1'b0 || lane_0 !== IW || lane_1 !== IW ||
        word_count !== 16'd12) begin
      errors++;
      $display("FAIL dis_drop: got st=%b l0=%h l1=%h v=%b%b wc=%0d, want st=00 idle lanes wc=12",
               state_out, lane_0, lane_1, valid_1, valid_0, word_count);
    end
    valid_in = 1'b0;
    train_and_check(1'b0);
    valid_in = 1'b1;
    data_in = 32'h55550001;
    tick();
    valid_in = 1'b0;
    checks++;
    if (valid_0 !== 1'b1 || valid_1 !== 1'b0 || lane_0 !== 32'h55550001 || lane_1 !== IW || word_count !== 16'd13) begin
      errors++;
      $display("FAIL dis_reenable: got l0=%h l1=%h v=%b%b wc=%0d, want l0=55550001 v=01 wc=13",
               lane_0, lane_1, valid_1, valid_0, word_count);
    end
  endtask

  task automatic test_async_reset_wrap();
    valid_in = 1'b1;
    data_in = 32'h66660001;
    tick();
    valid_in = 1'b0;
    #3;
    reset = 1'b1;
    enable = 1'b0;
    #1;
    checks++;
    if (state_out !== 2'b00 || lane_0 !== IW || lane_1 !== IW || valid_0 !== 1'b0 || valid_1 !== 1'b0 ||
        training !== 1'b0 || word_count !== 16'd0 || ready_out !== 1'b0 || s_wc !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: got st=%b l0=%h l1=%h v=%b%b trn=%b wc=%0d rdy=%b wc4=%0d",
               state_out, lane_0, lane_1, valid_1, valid_0, training, word_count, ready_out, s_wc);
    end
    @(posedge clk_2f);
    #1;
    reset = 1'b0;
    train_and_check(1'b1);
    for (int i = 0; i < 17; i++) begin
      valid_in = 1'b1;
      data_in = 32'h70000000 + i;
      tick();
      if (i == 15) begin
        checks++;
        if (s_wc !== 4'd0 || word_count !== 16'd16) begin
          errors++;
          $display("FAIL wrap_16: got wc4=%0d wc=%0d, want wc4=0 wc=16", s_wc, word_count);
        end
      end
    end
    valid_in = 1'b0;
    tick();
    checks++;
    if (s_wc !== 4'd1 || word_count !== 16'd17) begin
      errors++;
      $display("FAIL wrap_17: got wc4=%0d wc=%0d, want wc4=1 wc=17", s_wc, word_count);
    end
  endtask

  initial begin
    test_reset();
    test_dual_striping();
    test_gap();
    test_single_lane();
    test_disable_reenable();
    test_async_reset_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
